// File: rtl/multi_cycle_core_pkg.sv
// Shared definitions for the multi-cycle RV core: opcode constants,
// the ebreak encoding and the control state enum.
package multi_cycle_core_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    // funct3 of the only load/store width supported: ld/sd or lw/sw
    function automatic logic [2:0] ls_funct3(input int xlen);
        return (xlen == 64) ? 3'b011 : 3'b010;
    endfunction

endpackage

// File: rtl/multi_cycle_core_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous
// write port. Ports: clk, rs1/rs2 addr+data (read), rd_we/rd_addr/rd_data (write).
module multi_cycle_core_regfile #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data
);

    logic [XLEN-1:0] regs [32];

    // x0 is never written and is forced to read as zero
    assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

    always_ff @(posedge clk) begin
        if (rd_we && rd_addr != 5'd0) begin
            regs[rd_addr] <= rd_data;
        end
    end

endmodule

// File: rtl/multi_cycle_core.sv
// Multi-cycle RV32/RV64 subset core (FETCH/EXEC/MEM/WB/HALT) with
// req/valid instruction and data ports, pc, halted and illegal outputs.
module multi_cycle_core
    import multi_cycle_core_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    localparam logic [2:0] LS_F3 = ls_funct3(XLEN);

    state_t          state;
    state_t          state_n;
    logic [31:0]     ir;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] ldata;
    logic            halt_r;
    logic            ill_r;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] f3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] f7;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_u;

    assign imm_i = {{(XLEN-11){ir[31]}}, ir[30:20]};
    assign imm_s = {{(XLEN-11){ir[31]}}, ir[30:25], ir[11:7]};
    assign imm_b = {{(XLEN-12){ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u = {{(XLEN-31){ir[31]}}, ir[30:12], 12'b0};

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_addi, is_add, is_sub, is_load, is_store;
    logic is_ebreak, legal;

    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR && f3 == 3'b000;
    assign is_branch = opcode == OP_BRANCH && f3[2:1] == 2'b00;
    assign is_addi   = opcode == OP_IMM && f3 == 3'b000;
    assign is_add    = opcode == OP_REG && f3 == 3'b000 && f7 == 7'b0000000;
    assign is_sub    = opcode == OP_REG && f3 == 3'b000 && f7 == 7'b0100000;
    assign is_load   = opcode == OP_LOAD && f3 == LS_F3;
    assign is_store  = opcode == OP_STORE && f3 == LS_F3;
    assign is_ebreak = ir == EBREAK;

    assign legal = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                   is_addi | is_add | is_sub | is_load | is_store;

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] wb_data;
    logic            rf_we;

    // Stores and branches never write back; reset suppresses a late WB
    assign rf_we = state == WB && !rst && !is_store && !is_branch;

    multi_cycle_core_regfile #(
        .XLEN(XLEN)
    ) regfile (
        .clk      (clk),
        .rs1_addr (rs1),
        .rs1_data (rs1_data),
        .rs2_addr (rs2),
        .rs2_data (rs2_data),
        .rd_we    (rf_we),
        .rd_addr  (rd),
        .rd_data  (wb_data)
    );

    logic [XLEN-1:0] pc_plus4;
    logic            taken;

    assign pc_plus4 = pc_r + XLEN'(4);
    // f3[0] selects bne: invert the equality result
    assign taken    = (rs1_data == rs2_data) ^ f3[0];

    always_comb begin
        wb_data = '0;
        if (is_lui) begin
            wb_data = imm_u;
        end else if (is_auipc) begin
            wb_data = pc_r + imm_u;
        end else if (is_jal || is_jalr) begin
            wb_data = pc_plus4;
        end else if (is_addi) begin
            wb_data = rs1_data + imm_i;
        end else if (is_add) begin
            wb_data = rs1_data + rs2_data;
        end else if (is_sub) begin
            wb_data = rs1_data - rs2_data;
        end else if (is_load) begin
            wb_data = ldata;
        end
    end

    always_comb begin
        pc_n = pc_plus4;
        if (is_jal) begin
            pc_n = pc_r + imm_j;
        end else if (is_jalr) begin
            pc_n = (rs1_data + imm_i) & ~XLEN'(1);
        end else if (is_branch && taken) begin
            pc_n = pc_r + imm_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FETCH: begin
                if (imem_valid) state_n = EXEC;
            end
            EXEC: begin
                if (is_ebreak || !legal) begin
                    state_n = HALT;
                end else if (is_load || is_store) begin
                    state_n = MEM;
                end else begin
                    state_n = WB;
                end
            end
            MEM: begin
                if (dmem_valid) state_n = WB;
            end
            WB:      state_n = FETCH;
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r   <= RESET_PC[XLEN-1:0];
            ir     <= '0;
            halt_r <= 1'b0;
            ill_r  <= 1'b0;
        end else begin
            if (state == FETCH && imem_valid) ir <= imem_rdata;
            if (state == EXEC) begin
                if (is_ebreak) begin
                    halt_r <= 1'b1;
                end else if (!legal) begin
                    ill_r <= 1'b1;
                end
            end
            if (state == WB) pc_r <= pc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == MEM && dmem_valid) begin
            ldata <= dmem_rdata;
        end
    end

    // Request lines are forced low during reset so an in-flight access
    // is dropped in the same cycle reset is seen
    assign imem_req   = state == FETCH && !rst;
    assign imem_addr  = pc_r;
    assign dmem_req   = state == MEM && !rst;
    assign dmem_we    = state == MEM && !rst && is_store;
    assign dmem_addr  = rs1_data + (is_store ? imm_s : imm_i);
    assign dmem_wdata = rs2_data;
    assign pc         = pc_r;
    assign halted     = halt_r;
    assign illegal    = ill_r;

endmodule

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values are 32 and 64.
REQ-002 Parameter RESET_PC, default 64'h0000_0000_8000_0000 truncated to XLEN, PC after reset.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 imem_req  out  1  instruction fetch request, held until imem_valid.
REQ-006 imem_addr  out  XLEN  fetch address, equal to pc.
REQ-007 imem_valid  in  1  fetch data valid this cycle.
REQ-008 imem_rdata  in  32  instruction word.
REQ-009 dmem_req  out  1  data access request, held until dmem_valid.
REQ-010 dmem_we  out  1  1 = store, 0 = load.
REQ-011 dmem_addr  out  XLEN  rs1 + sign-extended offset.
REQ-012 dmem_wdata  out  XLEN  rs2 value for stores.
REQ-013 dmem_valid  in  1  load data valid / store accepted.
REQ-014 dmem_rdata  in  XLEN  load data.
REQ-015 pc  out  XLEN  address of the current instruction.
REQ-016 halted  out  1  core stopped on ebreak (32'h0010_0073).
REQ-017 illegal  out  1  core stopped on an unsupported encoding.

Function
REQ-018 States: FETCH, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1. On imem_valid, latch imem_rdata into the IR and go to EXEC.
- EXEC: decode, compute. Load/store goes to MEM. Ebreak or illegal goes to HALT. All others go to WB.
- MEM: dmem_req=1. On dmem_valid, latch load data and go to WB.
- WB: write the regfile, update pc, go to FETCH.
- HALT: absorbing until rst.
REQ-019 Supported instructions:
- lui, auipc, jal, jalr, beq, bne, addi, add, sub.
- Load/store of XLEN width: funct3 011 (ld/sd) when XLEN=64, funct3 010 (lw/sw) when XLEN=32.
- Any other encoding raises illegal.
REQ-020 Immediates are sign-extended to XLEN. U-type result is {imm[31:12],12'b0} sign-extended.
REQ-021 Arithmetic is modulo 2^XLEN; overflow is ignored.
REQ-022 Next pc in WB:
- jal: pc + J-imm.
- jalr: (rs1 + I-imm) with bit0 cleared.
- beq/bne taken: pc + B-imm.
- Otherwise: pc + 4.
REQ-023 jal and jalr write pc + 4 to rd. Stores and branches perform no regfile write.
REQ-024 Writes to x0 are discarded; x0 always reads 0.
REQ-025 Handshake:
- While a req is asserted, addr, wdata and we remain stable.
- A valid arriving while req=0 is ignored.
- Valid in the same cycle as req rise completes the access; minimum fetch latency is 1 cycle.
REQ-026 Minimum cycles per instruction:
- ALU/branch/jump: 3 (FETCH, EXEC, WB).
- Load/store: 4 (adds MEM).
- Each wait cycle on imem/dmem valid adds 1.
REQ-027 In HALT, imem_req=0, dmem_req=0 and pc holds; halted or illegal is held at 1.
REQ-028 pc wraps modulo 2^XLEN with no exception; a misaligned jump target is not trapped.

Reset
REQ-029 While rst=1, each cycle sets:
- pc = RESET_PC, state = FETCH.
- imem_req = dmem_req = dmem_we = 0.
- halted = illegal = 0.
- IR cleared to 0.
REQ-030 Reset asserted mid-fetch or mid-access abandons the transaction; dmem_valid or imem_valid arriving afterwards is ignored.
REQ-031 Regfile contents are not reset; x0 remains 0.
REQ-032 First imem_req=1 occurs in the cycle after rst deasserts.

Structure
REQ-033 Shared package holds:
- Opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG.
- EBREAK encoding.
- State enum.
REQ-034 The 32xXLEN register file is a sub-module, regfile: two asynchronous read ports, one synchronous write port.

Verification
REQ-035 Reset release: rst 1→0 → pc=0x80000000; imem_req=1 next cycle; dmem_req=0.
REQ-036 addi x1,x0,5 then add x2,x1,x1 (imem_valid same cycle) → x2=10; each instruction takes 3 cycles.
REQ-037 sd x2,8(x0) with dmem_valid delayed 2 cycles → dmem_addr=8 and dmem_wdata=10 held stable 3 cycles; pc advances by 4.
REQ-038 beq x0,x0,-8 at pc 0x80000010 → next pc 0x80000008; bne x0,x0 → 0x80000014.
REQ-039 jalr x1,3(x5) with x5=0x80000100 → pc=0x80000102; x1=old pc+4.
REQ-040 ebreak → halted=1, pc frozen, no further imem_req; encoding 0xFFFFFFFF → illegal=1; rst mid-MEM → dmem_req drops, pc=RESET_PC.
